// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing and perf counters.
// Latency: one cycle from ID to EX; stall is combinational in the same cycle.
// Backpressure: stall holds PC and IF/ID for one cycle while a bubble enters EX; flush beats stall.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_RegDst,
    input  logic        id_ALUSrc,
    input  logic        id_MemtoReg,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_Branch,
    input  logic [1:0]  id_ALUOp,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc4,
    input  logic [5:0]  id_funct,
    input  logic        ex_flush,
    output logic        ex_valid,
    output logic        ex_RegDst,
    output logic        ex_ALUSrc,
    output logic        ex_MemtoReg,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_Branch,
    output logic [1:0]  ex_ALUOp,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc4,
    output logic [5:0]  ex_funct,
    output logic        stall,
    output logic [15:0] stall_count,
    output logic [15:0] bubble_count
);

    logic        usesRt;
    logic        hazard;
    logic        killCtrl;
    logic        bubbleIns;
    logic [15:0] stallCount;
    logic [15:0] bubbleCount;

    // Stores and R-type ops read rt; I-type ALU ops and loads only read rs.
    assign usesRt = !id_ALUSrc || id_MemWrite;
    assign hazard = ex_valid && ex_MemRead && (ex_rt != 5'd0) && id_valid &&
                    ((ex_rt == id_rs) || (usesRt && (ex_rt == id_rt)));
    assign stall  = hazard && !ex_flush;

    assign killCtrl  = ex_flush || hazard || !id_valid;
    assign bubbleIns = (ex_flush || hazard) && id_valid;

    assign stall_count  = stallCount;
    assign bubble_count = bubbleCount;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_RegDst   <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_rd       <= 5'd0;
            ex_rs_data  <= 32'd0;
            ex_rt_data  <= 32'd0;
            ex_imm      <= 32'd0;
            ex_pc4      <= 32'd0;
            ex_funct    <= 6'd0;
            stallCount  <= 16'd0;
            bubbleCount <= 16'd0;
        end else begin
            // Data and indices always follow ID so a bubble carries deterministic payload.
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
            ex_funct   <= id_funct;
            if (killCtrl) begin
                ex_valid    <= 1'b0;
                ex_RegDst   <= 1'b0;
                ex_ALUSrc   <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_Branch   <= 1'b0;
                ex_ALUOp    <= 2'b00;
            end else begin
                ex_valid    <= 1'b1;
                ex_RegDst   <= id_RegDst;
                ex_ALUSrc   <= id_ALUSrc;
                ex_MemtoReg <= id_MemtoReg;
                ex_RegWrite <= id_RegWrite;
                ex_MemRead  <= id_MemRead;
                ex_MemWrite <= id_MemWrite;
                ex_Branch   <= id_Branch;
                ex_ALUOp    <= id_ALUOp;
            end
            if (stall && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end
            if (bubbleIns && (bubbleCount != 16'hFFFF)) begin
                bubbleCount <= bubbleCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model of the EX slot is checked every cycle,
// plus literal expectations for the load-use, store, flush, saturation and reset scenarios.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
    logic [1:0]  id_ALUOp;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic [5:0]  id_funct;
    logic        ex_flush;
    logic        ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
    logic [1:0]  ex_ALUOp;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [5:0]  ex_funct;
    logic        stall;
    logic [15:0] stall_count, bubble_count;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_ALUOp(id_ALUOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_pc4(id_pc4), .id_funct(id_funct), .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
        .ex_ALUOp(ex_ALUOp), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_funct(ex_funct),
        .stall(stall), .stall_count(stall_count), .bubble_count(bubble_count)
    );

    // Control word order: {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch}
    localparam logic [6:0] CLW = 7'b0111100;
    localparam logic [6:0] CSW = 7'b0100010;
    localparam logic [6:0] CRT = 7'b1001000;

    typedef struct {
        logic        valid;
        logic [6:0]  ctrl;
        logic [1:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm, pc4;
        logic [5:0]  funct;
    } instr_t;

    instr_t mEx;
    int     stallEvents, bubbleEvents;
    int     stallOffset;
    logic   mInit;
    int     nChecks, nPass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Load-use rule stated at instruction level: the instruction in EX is a valid load whose
    // destination (rt, nonzero) is a source register the ID instruction actually reads.
    function automatic logic modelHazard(instr_t e);
        logic readsRt;
        readsRt = (id_ALUSrc == 1'b0) || (id_MemWrite == 1'b1);
        if (!e.valid || !e.ctrl[2] || e.rt == 5'd0 || !id_valid) return 1'b0;
        return (e.rt == id_rs) || (readsRt && e.rt == id_rt);
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    always @(posedge clk) begin
        logic hz;
        if (!rst_n) begin
            mEx = '{valid: 1'b0, ctrl: 7'd0, op: 2'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0,
                    rsd: 32'd0, rtd: 32'd0, imm: 32'd0, pc4: 32'd0, funct: 6'd0};
            stallEvents  = 0;
            bubbleEvents = 0;
            mInit = 1'b1;
        end else if (mInit) begin
            hz = modelHazard(mEx);
            if (hz && !ex_flush) stallEvents++;
            if ((hz || ex_flush) && id_valid) bubbleEvents++;
            mEx.rs = id_rs; mEx.rt = id_rt; mEx.rd = id_rd;
            mEx.rsd = id_rs_data; mEx.rtd = id_rt_data; mEx.imm = id_imm; mEx.pc4 = id_pc4;
            mEx.funct = id_funct;
            if (ex_flush || hz || !id_valid) begin
                mEx.valid = 1'b0; mEx.ctrl = 7'd0; mEx.op = 2'd0;
            end else begin
                mEx.valid = 1'b1;
                mEx.ctrl = {id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch};
                mEx.op = id_ALUOp;
            end
        end
    end

    always @(negedge clk) begin
        if (mInit) begin
            chk("stall", {31'd0, stall}, {31'd0, modelHazard(mEx) && !ex_flush});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, mEx.valid});
            chk("ex_ctrl", {25'd0, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch},
                {25'd0, mEx.ctrl});
            chk("ex_ALUOp", {30'd0, ex_ALUOp}, {30'd0, mEx.op});
            chk("ex_regs", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, mEx.rs, mEx.rt, mEx.rd});
            chk("ex_rs_data", ex_rs_data, mEx.rsd);
            chk("ex_rt_data", ex_rt_data, mEx.rtd);
            chk("ex_imm", ex_imm, mEx.imm);
            chk("ex_pc4", ex_pc4, mEx.pc4);
            chk("ex_funct", {26'd0, ex_funct}, {26'd0, mEx.funct});
            chk("stall_count", {16'd0, stall_count}, {16'd0, sat16(stallOffset + stallEvents)});
            chk("bubble_count", {16'd0, bubble_count}, {16'd0, sat16(bubbleEvents)});
        end
    end

    int seqNo;

    task automatic drive(input logic v, input logic [6:0] c, input logic [1:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic fl);
        seqNo++;
        id_valid = v;
        {id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch} = c;
        id_ALUOp   = op;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_data = rsd;
        id_rt_data = rsd ^ 32'hA5A5_0000;
        id_imm     = {16'hFFFF, 11'd0, rd};
        id_pc4     = 32'h0000_0400 + 32'(seqNo * 4);
        id_funct   = 6'h20 ^ {1'b0, rd};
        ex_flush   = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nChecks = 0; nPass = 0; mInit = 1'b0; stallOffset = 0; seqNo = 0;
        stallEvents = 0; bubbleEvents = 0;
        rst_n = 1'b0;
        drive(1'b0, 7'd0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        step(); step();
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst counters", {stall_count, bubble_count}, 32'd0);
        rst_n = 1'b1;
        #1 chk("stall after reset", {31'd0, stall}, 32'd0);

        // Load-use: lw $8 then add using $8
        drive(1'b1, CLW, 2'b00, 5'd1, 5'd8, 5'd0, 32'h11, 1'b0);
        step();
        chk("lw in EX MemRead/rt", {26'd0, ex_MemRead, ex_rt}, {26'd0, 1'b1, 5'd8});
        drive(1'b1, CRT, 2'b10, 5'd8, 5'd9, 5'd10, 32'h22, 1'b0);
        #1 chk("load-use stall", {31'd0, stall}, 32'd1);
        step();
        chk("bubble ctrl", {23'd0, ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
                            ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp}, 32'd0);
        chk("counts after load-use", {stall_count, bubble_count}, {16'd1, 16'd1});
        chk("stall one cycle only", {31'd0, stall}, 32'd0);
        step();
        chk("add enters EX", {29'd0, ex_valid, ex_RegDst, ex_RegWrite}, 32'd7);

        // Load whose rt matches, but a load does not read rt
        drive(1'b1, CLW, 2'b00, 5'd1, 5'd8, 5'd0, 32'h33, 1'b0);
        step();
        drive(1'b1, CLW, 2'b00, 5'd4, 5'd8, 5'd0, 32'h44, 1'b0);
        #1 chk("lw-lw no stall", {31'd0, stall}, 32'd0);
        step();
        chk("second lw in EX", {26'd0, ex_MemRead, ex_rt}, {26'd0, 1'b1, 5'd8});

        // Store reads rt -> stall
        drive(1'b1, CSW, 2'b00, 5'd4, 5'd8, 5'd0, 32'h55, 1'b0);
        #1 chk("sw stall", {31'd0, stall}, 32'd1);
        step();
        step();
        // Register zero never hazards
        drive(1'b1, CLW, 2'b00, 5'd1, 5'd0, 5'd0, 32'h66, 1'b0);
        step();
        drive(1'b1, CSW, 2'b00, 5'd0, 5'd0, 5'd0, 32'h77, 1'b0);
        #1 chk("index 0 no stall", {31'd0, stall}, 32'd0);
        step();

        // Hazard with simultaneous flush
        drive(1'b1, CLW, 2'b00, 5'd1, 5'd8, 5'd0, 32'h88, 1'b0);
        step();
        chk("pre-flush counts", {stall_count, bubble_count}, {16'd2, 16'd2});
        drive(1'b1, CRT, 2'b10, 5'd8, 5'd9, 5'd3, 32'h99, 1'b1);
        #1 chk("flush masks stall", {31'd0, stall}, 32'd0);
        step();
        chk("flush bubble", {31'd0, ex_valid}, 32'd0);
        chk("flush counts", {stall_count, bubble_count}, {16'd2, 16'd3});

        // Invalid ID slot with matching fields
        drive(1'b1, CLW, 2'b00, 5'd1, 5'd8, 5'd0, 32'haa, 1'b0);
        step();
        drive(1'b0, CRT, 2'b10, 5'd8, 5'd8, 5'd3, 32'hbb, 1'b0);
        #1 chk("invalid no stall", {31'd0, stall}, 32'd0);
        step();
        chk("invalid loads bubble", {30'd0, ex_valid, ex_RegWrite}, 32'd0);
        chk("invalid no bubble count", {16'd0, bubble_count}, 32'd3);

        // Saturation: preload the counter just below the top
        force dut.stallCount = 16'hFFFE;
        stallOffset = 32'h0000_FFFE - stallEvents;
        #1 release dut.stallCount;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, CLW, 2'b00, 5'd1, 5'd8, 5'd0, 32'hc0, 1'b0);
            step();
            drive(1'b1, CRT, 2'b10, 5'd8, 5'd9, 5'd3, 32'hc1, 1'b0);
            step();
            chk("stall_count saturates", {16'd0, stall_count}, 32'h0000_FFFF);
        end

        // R-type then reset
        drive(1'b1, CRT, 2'b10, 5'd2, 5'd3, 5'd4, 32'h0000_0005, 1'b0);
        step();
        chk("rtype rs_data", ex_rs_data, 32'h0000_0005);
        rst_n = 1'b0;
        step();
        stallOffset = 0;
        chk("reset ctrl", {22'd0, ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
                           ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp}, 32'd0);
        chk("reset data", ex_rs_data | ex_rt_data | ex_imm | ex_pc4 | {11'd0, ex_rs, ex_rt, ex_rd, ex_funct}, 32'd0);
        chk("reset counters", {stall_count, bubble_count}, 32'd0);
        rst_n = 1'b1;

        // Reset arriving mid-stall discards the bubble and the count
        drive(1'b1, CLW, 2'b00, 5'd1, 5'd8, 5'd0, 32'hd0, 1'b0);
        step();
        drive(1'b1, CRT, 2'b10, 5'd8, 5'd9, 5'd3, 32'hd1, 1'b0);
        #1 chk("stall before reset", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid-stall reset counters", {stall_count, bubble_count}, 32'd0);
        chk("mid-stall reset stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        step();
        step();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The module SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 id_valid  input  1  ID stage holds a real instruction this cycle.
REQ-005 id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch  input  1 each  decoded control from the control unit.
REQ-006 id_ALUOp  input  2  ALU operation class from the control unit.
REQ-007 id_rs, id_rt, id_rd  input  5 each  register indices.
REQ-008 id_rs_data, id_rt_data, id_imm, id_pc4  input  32 each  operands, sign-extended immediate, PC+4.
REQ-009 id_funct  input  6  function field.
REQ-010 ex_flush  input  1  branch taken in EX; squash the instruction in ID.
REQ-011 ex_* outputs  output  same widths as id_* (REQ-005..REQ-009)  registered copies for EX.
REQ-012 ex_valid  output  1  ex_* holds a real instruction.
REQ-013 stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-014 stall_count, bubble_count  output  16 each  performance counters.

Function
REQ-015 uses_rt SHALL be (!id_ALUSrc || id_MemWrite).
REQ-016 hazard SHALL be 1 iff ex_valid && ex_MemRead && ex_rt != 0 && id_valid && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt)).
REQ-017 stall SHALL equal hazard && !ex_flush; same cycle, no latency.
REQ-018 Load (normal): if !ex_flush && !hazard, all ex_* SHALL take id_* at the edge and ex_valid SHALL take id_valid; latency exactly 1 cycle.
REQ-019 Bubble: if hazard && !ex_flush, control outputs (7 single bits, ex_ALUOp) SHALL become 0, ex_valid 0; data/index outputs don't-care but SHALL be loaded from id_* for determinism.
REQ-020 Flush: if ex_flush, control outputs and ex_valid SHALL become 0 regardless of hazard; flush has priority over stall.
REQ-021 A load-use stall SHALL last exactly one cycle, since the inserted bubble clears ex_MemRead.
REQ-022 id_valid=0 SHALL load a bubble (controls zeroed, ex_valid 0) and never raise stall.
REQ-023 stall_count SHALL increment by 1 each cycle stall=1, saturating at 16'hFFFF.
REQ-024 bubble_count SHALL increment by 1 each cycle a bubble is inserted via REQ-019 or REQ-020 while id_valid=1, saturating at 16'hFFFF.
REQ-025 Index 0 SHALL never create a hazard.

Reset
REQ-026 While rst_n=0 at an edge, every ex_* output, ex_valid, stall_count and bubble_count SHALL become 0; reset overrides flush and hazard.
REQ-027 stall SHALL read 0 in the cycle after reset because ex_valid=0.
REQ-028 Reset asserted mid-stall SHALL discard the pending bubble; no counter increment occurs on that edge.

Verification
REQ-029 lw into EX (ex_MemRead=1, ex_rt=8), ID add rs=8 rt=9 valid -> stall=1 same cycle, next edge ex_valid=0 with all controls 0, stall_count=1, bubble_count=1, and the following cycle stall=0.
REQ-030 lw ex_rt=8, ID lw rs=4 rt=8 (ALUSrc=1, MemWrite=0) -> no stall; ex_MemRead=1, ex_rt=8 next cycle.
REQ-031 lw ex_rt=8, ID sw rt=8 -> stall=1; repeat with ex_rt=0 and id_rs=0 -> stall=0.
REQ-032 Hazard and ex_flush together -> stall=0, next ex_valid=0, bubble_count+1, stall_count unchanged.
REQ-033 Force stall_count to 16'hFFFF via 65535 stall cycles, one more stall -> stays 16'hFFFF.
REQ-034 R-type (RegDst=1, RegWrite=1, ALUOp=2'b10, rs_data=32'h0000_0005) in ID, then rst_n=0 for one edge -> all outputs 0, counters 0.
